alu_addsub_seq: RTL and testbench

//   Parametrised control sequencer for the ALU add/sub datapath (M, Q, A registers, byte output mux).

---
 rtl/alu_ctrl_pkg.sv | 27 ++
 rtl/alu_out_byte_seq.sv | 49 ++++
 rtl/alu_addsub_seq.sv | 141 ++++++++++++++
 tb/tb_alu_addsub_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU add/sub control sequencer: FSM states,
// ctrl strobe bit positions and op codes.
package alu_ctrl_pkg;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WAIT_FALL = 3'd1;
    localparam logic [2:0] STAB      = 3'd2;
    localparam logic [2:0] LOAD_Q    = 3'd3;
    localparam logic [2:0] EXEC      = 3'd4;
    localparam logic [2:0] OUT       = 3'd5;

    localparam int CTRL_W      = 11;
    localparam int CTRL_LOAD_M = 0;
    localparam int CTRL_LOAD_Q = 1;
    localparam int CTRL_EXEC   = 2;
    localparam int CTRL_SUB    = 3;
    localparam int CTRL_CARRY  = 4;
    localparam int CTRL_FLAGS  = 5;
    localparam int CTRL_BYTE   = 7;
    localparam int CTRL_LAST   = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_SBB = 2'b11;

endpackage

// File: rtl/alu_out_byte_seq.sv
// Result byte streamer: MSB-first down-counter with valid/ack handshake.
// Index is loaded during EXEC, steps on each accepted byte, cleared on abort.
module alu_out_byte_seq #(
    parameter int OUT_BYTES = 2,
    parameter int BSEL_W    = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic              active_i,
    input  logic              ack_i,
    output logic [BSEL_W-1:0] byte_idx_o,
    output logic              valid_o,
    output logic              fire_o,
    output logic              last_o
);

    localparam logic [BSEL_W-1:0] IDX_TOP = BSEL_W'(OUT_BYTES - 1);
    localparam logic [BSEL_W-1:0] IDX_ONE = BSEL_W'(1);

    logic [BSEL_W-1:0] byte_idx_q;
    logic [BSEL_W-1:0] byte_idx_d;

    assign valid_o    = active_i;
    assign fire_o     = active_i & ack_i;
    assign last_o     = (byte_idx_q == '0);
    assign byte_idx_o = byte_idx_q;

    always_comb begin
        byte_idx_d = byte_idx_q;
        if (clr_i) begin
            byte_idx_d = '0;
        end else if (load_i) begin
            byte_idx_d = IDX_TOP;
        end else if (fire_o && !last_o) begin
            byte_idx_d = byte_idx_q - IDX_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            byte_idx_q <= '0;
        end else begin
            byte_idx_q <= byte_idx_d;
        end
    end

endmodule

// File: rtl/alu_addsub_seq.sv
// Control sequencer for the ALU add/sub datapath: load M, settle, load Q,
// execute, then stream the result bytes under valid/ack; done pulses after the last byte.
module alu_addsub_seq
    import alu_ctrl_pkg::*;
#(
    parameter  int DATA_W      = 16,
    parameter  int STAB_CYCLES = 1,
    localparam int OUT_BYTES   = DATA_W / 8,
    localparam int BSEL_W      = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enable_i,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic              out_ack_i,
    output logic [10:0]       ctrl_o,
    output logic [BSEL_W-1:0] byte_sel_o,
    output logic              out_valid_o,
    output logic              ready_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int STAB_W = (STAB_CYCLES > 1) ? $clog2(STAB_CYCLES) : 1;
    localparam int STAB_INIT = (STAB_CYCLES > 0) ? STAB_CYCLES - 1 : 0;
    localparam logic [STAB_W-1:0] STAB_LOAD = STAB_W'(STAB_INIT);
    localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);

    logic [2:0]        state_q, state_d;
    logic [1:0]        op_lat_q, op_lat_d;
    logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
    logic              done_q, done_d;

    logic              byte_fire;
    logic              byte_last;
    logic              byte_vld;

    alu_out_byte_seq #(
        .OUT_BYTES (OUT_BYTES),
        .BSEL_W    (BSEL_W)
    ) u_out_byte_seq (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (!enable_i),
        .load_i     (enable_i && (state_q == EXEC)),
        .active_i   (enable_i && (state_q == OUT)),
        .ack_i      (out_ack_i),
        .byte_idx_o (byte_sel_o),
        .valid_o    (byte_vld),
        .fire_o     (byte_fire),
        .last_o     (byte_last)
    );

    always_comb begin
        state_d    = state_q;
        op_lat_d   = op_lat_q;
        stab_cnt_d = stab_cnt_q;
        done_d     = 1'b0;
        if (!enable_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d  = WAIT_FALL;
                        op_lat_d = op_i;
                    end
                end
                WAIT_FALL: begin
                    // Sequence launches on the falling edge of the start level.
                    if (!start_i) begin
                        if (STAB_CYCLES == 0) begin
                            state_d = LOAD_Q;
                        end else begin
                            state_d    = STAB;
                            stab_cnt_d = STAB_LOAD;
                        end
                    end
                end
                STAB: begin
                    if (stab_cnt_q == '0) begin
                        state_d = LOAD_Q;
                    end else begin
                        stab_cnt_d = stab_cnt_q - STAB_ONE;
                    end
                end
                LOAD_Q:  state_d = EXEC;
                EXEC:    state_d = OUT;
                OUT: begin
                    if (byte_fire && byte_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        ctrl_o = '0;
        if (enable_i) begin
            case (state_q)
                WAIT_FALL: ctrl_o[CTRL_LOAD_M] = !start_i;
                LOAD_Q:    ctrl_o[CTRL_LOAD_Q] = 1'b1;
                EXEC: begin
                    ctrl_o[CTRL_EXEC]  = 1'b1;
                    ctrl_o[CTRL_SUB]   = op_lat_q[0];
                    ctrl_o[CTRL_CARRY] = op_lat_q[1];
                    ctrl_o[CTRL_FLAGS] = 1'b1;
                end
                OUT: begin
                    ctrl_o[CTRL_BYTE] = byte_fire & !byte_last;
                    ctrl_o[CTRL_LAST] = byte_fire & byte_last;
                end
                default: ctrl_o = '0;
            endcase
        end
    end

    assign out_valid_o = byte_vld;
    assign ready_o     = enable_i && (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            op_lat_q   <= OP_ADD;
            stab_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_lat_q   <= op_lat_d;
            stab_cnt_q <= stab_cnt_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_alu_addsub_seq.sv
// Directed bench for alu_addsub_seq: four instances (16b/S=1, 32b/S=1,
// 16b/S=0, 16b/S=3) share one stimulus stream; each check targets one instance.
module tb_alu_addsub_seq;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       start;
    logic [1:0] op;
    logic       ack;

    logic [10:0] a_ctrl, b_ctrl, c_ctrl, e_ctrl;
    logic        a_sel, c_sel, e_sel;
    logic [1:0]  b_sel;
    logic        a_vld, b_vld, c_vld, e_vld;
    logic        a_rdy, b_rdy, c_rdy, e_rdy;
    logic        a_busy, b_busy, c_busy, e_busy;
    logic        a_done, b_done, c_done, e_done;

    int vec_cnt = 0;
    int err_cnt = 0;
    int strobes;
    int dones;
    bit found;

    alu_addsub_seq #(.DATA_W(16), .STAB_CYCLES(1)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .start_i(start), .op_i(op),
        .out_ack_i(ack), .ctrl_o(a_ctrl), .byte_sel_o(a_sel), .out_valid_o(a_vld),
        .ready_o(a_rdy), .busy_o(a_busy), .done_o(a_done));

    alu_addsub_seq #(.DATA_W(32), .STAB_CYCLES(1)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .start_i(start), .op_i(op),
        .out_ack_i(ack), .ctrl_o(b_ctrl), .byte_sel_o(b_sel), .out_valid_o(b_vld),
        .ready_o(b_rdy), .busy_o(b_busy), .done_o(b_done));

    alu_addsub_seq #(.DATA_W(16), .STAB_CYCLES(0)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .start_i(start), .op_i(op),
        .out_ack_i(ack), .ctrl_o(c_ctrl), .byte_sel_o(c_sel), .out_valid_o(c_vld),
        .ready_o(c_rdy), .busy_o(c_busy), .done_o(c_done));

    alu_addsub_seq #(.DATA_W(16), .STAB_CYCLES(3)) u_e (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .start_i(start), .op_i(op),
        .out_ack_i(ack), .ctrl_o(e_ctrl), .byte_sel_o(e_sel), .out_valid_o(e_vld),
        .ready_o(e_rdy), .busy_o(e_busy), .done_o(e_done));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        ack   = 1'b1;
        repeat (n) tick();
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        start  = 1'b0;
        op     = 2'b00;
        ack    = 1'b1;

        // reset state
        #3;
        chk("rst_ctrl", a_ctrl, 0);
        chk("rst_vld", a_vld, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_sel", a_sel, 0);
        chk("rst_done", a_done, 0);
        chk("rst_rdy_en0", a_rdy, 0);
        enable = 1'b1;
        #1;
        chk("rst_rdy_en1", a_rdy, 1);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: SUB, start high 3 cycles, ack tied high; also S=0 and S=3 latency
        op = 2'b01;
        start = 1'b1;
        #3 chk("t1_ready", a_rdy, 1);
        tick();
        #3 chk("t1_wait_busy", a_busy, 1);
        chk("t1_wait_ctrl", a_ctrl, 0);
        tick();
        #3 chk("t1_wait_ctrl2", a_ctrl, 0);
        tick();
        start = 1'b0;                                   // T
        #3 chk("t1_loadm", a_ctrl, 11'h001);
        chk("t6_s0_loadm", c_ctrl, 11'h001);
        chk("t6_s3_loadm", e_ctrl, 11'h001);
        tick();                                         // T+1
        #3 chk("t1_stab", a_ctrl, 0);
        chk("t6_s0_loadq", c_ctrl, 11'h002);
        tick();                                         // T+2
        #3 chk("t1_loadq", a_ctrl, 11'h002);
        chk("t6_s0_exec", c_ctrl, 11'h02C);
        chk("t6_s0_vld_early", c_vld, 0);
        tick();                                         // T+3
        #3 chk("t1_exec", a_ctrl, 11'h02C);
        chk("t6_s0_first_vld", c_vld, 1);
        tick();                                         // T+4
        #3 chk("t1_b1_vld", a_vld, 1);
        chk("t1_b1_sel", a_sel, 1);
        chk("t1_b1_strb", a_ctrl, 11'h080);
        tick();                                         // T+5
        #3 chk("t1_b0_sel", a_sel, 0);
        chk("t1_b0_strb", a_ctrl, 11'h100);
        chk("t6_s3_vld_early", e_vld, 0);
        tick();                                         // T+6
        #3 chk("t1_done", a_done, 1);
        chk("t1_ready_after", a_rdy, 1);
        chk("t1_idle_ctrl", a_ctrl, 0);
        chk("t6_s3_first_vld", e_vld, 1);
        tick();
        #3 chk("t1_done_pulse", a_done, 0);
        idle(10);

        // 2: 32-bit stream, two stall cycles before each ack
        op = 2'b00;
        ack = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        found = 1'b0;
        strobes = 0;
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            #3;
            if (b_vld) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        if (!found) chk("t2_vld_timeout", 0, 1);
        for (int i = 3; i >= 0; i--) begin
            for (int s = 0; s < 2; s++) begin
                ack = 1'b0;
                #3 chk("t2_stall_sel", b_sel, i);
                chk("t2_stall_vld", b_vld, 1);
                chk("t2_stall_strb", b_ctrl[8:7], 0);
                strobes += b_ctrl[7] + b_ctrl[8];
                dones += b_done;
                tick();
            end
            ack = 1'b1;
            #3 chk("t2_ack_sel", b_sel, i);
            chk("t2_ack_strb", b_ctrl[8:7], (i == 0) ? 2 : 1);
            strobes += b_ctrl[7] + b_ctrl[8];
            dones += b_done;
            tick();
        end
        #3 chk("t2_done", b_done, 1);
        dones += b_done;
        tick();
        #3 dones += b_done;
        chk("t2_ready", b_rdy, 1);
        chk("t2_strobe_cnt", strobes, 4);
        chk("t2_done_cnt", dones, 1);
        idle(10);

        // 3: ADC latched, op changed after latch
        op = 2'b10;
        start = 1'b1;
        tick();
        start = 1'b0;                                   // T
        op = 2'b01;
        #3 chk("t3_loadm", a_ctrl, 11'h001);
        tick();
        tick();
        #3 chk("t3_s0_exec", c_ctrl, 11'h034);
        tick();
        #3 chk("t3_exec", a_ctrl, 11'h034);
        idle(10);

        // 4: enable dropped in OUT at byte_sel=1
        op = 2'b00;
        start = 1'b1;
        tick();
        start = 1'b0;                                   // T
        repeat (4) tick();                              // T+4
        #3 chk("t4_pre_sel", a_sel, 1);
        enable = 1'b0;
        #1 chk("t4_abort_ctrl", a_ctrl, 0);
        chk("t4_abort_vld", a_vld, 0);
        tick();
        enable = 1'b1;
        #3 chk("t4_idle_busy", a_busy, 0);
        chk("t4_no_done", a_done, 0);
        chk("t4_ready", a_rdy, 1);
        tick();
        #3 chk("t4_no_done2", a_done, 0);
        enable = 1'b0;
        start = 1'b1;
        tick();
        #3 chk("t4_en0_start", a_busy, 0);
        enable = 1'b1;
        idle(5);

        // 5: async reset during EXEC
        op = 2'b01;
        start = 1'b1;
        tick();
        start = 1'b0;                                   // T
        repeat (3) tick();                              // T+3
        #3 chk("t5_exec", a_ctrl, 11'h02C);
        rst_n = 1'b0;
        #1 chk("t5_rst_ctrl", a_ctrl, 0);
        chk("t5_rst_busy", a_busy, 0);
        chk("t5_rst_vld", a_vld, 0);
        chk("t5_rst_sel", a_sel, 0);
        chk("t5_rst_done", a_done, 0);
        tick();
        rst_n = 1'b1;
        #3 chk("t5_ready", a_rdy, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        #3 chk("t5_restart_loadm", a_ctrl, 11'h001);
        tick();
        tick();
        #3 chk("t5_restart_loadq", a_ctrl, 11'h002);
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
